hazard_ctrl: RTL and testbench

Pipeline hazard and interrupt sequencer that drives the `stall` and `flush` controls of the IF/ID, ID/EX and EX/MEM buffers. It sits beside the decode stage and observes the ID-stage source registers and the EX-stage fields of the ID/EX bundle (MR, WB, WB_Address, taken jump). It sequences external interrupts through a PC push, a flags push and a vector fetch. Buffers honour `flush` only when their `stall` is 0, and every output here is generated with that rule in mind.

---
 rtl/hazard_pkg.sv | 49 ++++
 rtl/hazard_stats.sv | 39 +++
 rtl/hazard_ctrl.sv | 155 +++++++++++++++
 tb/tb_hazard_ctrl.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared hazard definitions: sequencer states, register-address width,
// priority-encoding constants and control bundle used by hazard and forwarding logic.
package hazard_pkg;

   localparam int REG_ADDR_W = 3;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_PUSH_PC,
      ST_PUSH_FLAGS,
      ST_VECTOR
   } hz_state_e;

   // Highest value wins; the forwarding unit ranks its sources the same way.
   typedef logic [2:0] hz_prio_t;
   localparam hz_prio_t PRIO_NONE     = 3'd0;
   localparam hz_prio_t PRIO_LOAD_USE = 3'd1;
   localparam hz_prio_t PRIO_FSM      = 3'd2;
   localparam hz_prio_t PRIO_JUMP     = 3'd3;
   localparam hz_prio_t PRIO_MEM_BUSY = 3'd4;

   typedef struct packed {
      logic stall_pc;
      logic stall_if_id;
      logic stall_id_ex;
      logic stall_ex_mem;
      logic flush_if_id;
      logic flush_id_ex;
      logic push_pc;
      logic push_flags;
      logic pc_sel_vec;
   } hz_ctl_t;

   function automatic logic raw_hit(input logic                  rd_en,
                                    input logic [REG_ADDR_W-1:0] src,
                                    input logic [REG_ADDR_W-1:0] wb_addr);
      return rd_en && (src == wb_addr);
   endfunction

   function automatic hz_prio_t prio_sel(input logic busy, input logic jmp,
                                         input logic fsm_act, input logic load_use);
      if (busy)          return PRIO_MEM_BUSY;
      else if (jmp)      return PRIO_JUMP;
      else if (fsm_act)  return PRIO_FSM;
      else if (load_use) return PRIO_LOAD_USE;
      else               return PRIO_NONE;
   endfunction

endpackage

// File: rtl/hazard_stats.sv
// Saturating event counters for pipeline stall and ID/EX flush cycles.
// Counts one per cycle the qualifying strobe is high; cleared by reset.
module hazard_stats
   import hazard_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        stall_i,
   input  logic        flush_i,
   output logic [15:0] stat_stalls_o,
   output logic [15:0] stat_flushes_o
);

   logic [15:0] stalls_q, stalls_d;
   logic [15:0] flushes_q, flushes_d;

   always_comb begin
      stalls_d  = stalls_q;
      flushes_d = flushes_q;
      if (stall_i && (stalls_q != 16'hFFFF))
         stalls_d = stalls_q + 16'd1;
      if (flush_i && (flushes_q != 16'hFFFF))
         flushes_d = flushes_q + 16'd1;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         stalls_q  <= '0;
         flushes_q <= '0;
      end else begin
         stalls_q  <= stalls_d;
         flushes_q <= flushes_d;
      end
   end

   assign stat_stalls_o  = stalls_q;
   assign stat_flushes_o = flushes_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline stall/flush and interrupt sequencer for IF/ID, ID/EX and EX/MEM buffers.
// Optional HAZARD_STATS_EN adds saturating stall/flush counters.
module hazard_ctrl
   import hazard_pkg::*;
#(
   parameter int VEC_CYCLES = 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [REG_ADDR_W-1:0] id_src1,
   input  logic [REG_ADDR_W-1:0] id_src2,
   input  logic                  id_use1,
   input  logic                  id_use2,
   input  logic                  ex_mr,
   input  logic                  ex_wb,
   input  logic [REG_ADDR_W-1:0] ex_wb_addr,
   input  logic                  ex_jmp_taken,
   input  logic                  mem_busy,
   input  logic                  int_req,
   output logic                  stall_pc,
   output logic                  stall_if_id,
   output logic                  stall_id_ex,
   output logic                  stall_ex_mem,
   output logic                  flush_if_id,
   output logic                  flush_id_ex,
   output logic                  int_push_pc,
   output logic                  int_push_flags,
   output logic                  pc_sel_vec
`ifdef HAZARD_STATS_EN
   ,
   output logic [15:0]           stat_stalls,
   output logic [15:0]           stat_flushes
`endif
);

   localparam int CNT_W = (VEC_CYCLES > 1) ? $clog2(VEC_CYCLES) : 1;
   localparam logic [CNT_W-1:0] VEC_LAST = CNT_W'(VEC_CYCLES - 1);

   hz_state_e        state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             int_pending_q, int_pending_d;
   logic             int_req_d_q;

   logic     load_use;
   logic     int_edge;
   logic     pend_now;
   hz_prio_t prio;
   hz_ctl_t  ctl;

   assign load_use = ex_mr && ex_wb &&
                     (raw_hit(id_use1, id_src1, ex_wb_addr) ||
                      raw_hit(id_use2, id_src2, ex_wb_addr));
   assign int_edge = int_req && !int_req_d_q;
   // An edge seen this cycle can launch the sequence on the same clock.
   assign pend_now = int_pending_q || int_edge;
   assign prio     = prio_sel(mem_busy, ex_jmp_taken, state_q != ST_IDLE, load_use);

   always_comb begin
      ctl           = '0;
      state_d       = state_q;
      cnt_d         = cnt_q;
      int_pending_d = pend_now;

      case (prio)
         PRIO_MEM_BUSY: begin
            ctl.stall_pc     = 1'b1;
            ctl.stall_if_id  = 1'b1;
            ctl.stall_id_ex  = 1'b1;
            ctl.stall_ex_mem = 1'b1;
         end
         PRIO_JUMP: begin
            ctl.flush_if_id = 1'b1;
            ctl.flush_id_ex = 1'b1;
         end
         PRIO_FSM: begin
            ctl.flush_if_id = 1'b1;
            ctl.stall_pc    = (state_q == ST_PUSH_PC) || (state_q == ST_PUSH_FLAGS);
         end
         PRIO_LOAD_USE: begin
            // stall_id_ex stays low so the bubble flush actually lands.
            ctl.stall_pc    = 1'b1;
            ctl.stall_if_id = 1'b1;
            ctl.flush_id_ex = 1'b1;
         end
         default: ;
      endcase

      if (!mem_busy) begin
         // Strobes follow the state even under a jump so none is lost.
         ctl.push_pc    = (state_q == ST_PUSH_PC);
         ctl.push_flags = (state_q == ST_PUSH_FLAGS);
         ctl.pc_sel_vec = (state_q == ST_VECTOR);

         case (state_q)
            ST_IDLE: begin
               if (pend_now && !ex_jmp_taken && !load_use) begin
                  state_d       = ST_PUSH_PC;
                  int_pending_d = 1'b0;
               end
            end
            ST_PUSH_PC:    state_d = ST_PUSH_FLAGS;
            ST_PUSH_FLAGS: begin
               state_d = ST_VECTOR;
               cnt_d   = '0;
            end
            ST_VECTOR: begin
               if (cnt_q == VEC_LAST) begin
                  state_d = ST_IDLE;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q       <= ST_IDLE;
         cnt_q         <= '0;
         int_pending_q <= 1'b0;
         int_req_d_q   <= 1'b0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         int_pending_q <= int_pending_d;
         int_req_d_q   <= int_req;
      end
   end

   // Reset gates every output so nothing leaks while reset is asserted.
   assign stall_pc       = reset && ctl.stall_pc;
   assign stall_if_id    = reset && ctl.stall_if_id;
   assign stall_id_ex    = reset && ctl.stall_id_ex;
   assign stall_ex_mem   = reset && ctl.stall_ex_mem;
   assign flush_if_id    = reset && ctl.flush_if_id;
   assign flush_id_ex    = reset && ctl.flush_id_ex;
   assign int_push_pc    = reset && ctl.push_pc;
   assign int_push_flags = reset && ctl.push_flags;
   assign pc_sel_vec     = reset && ctl.pc_sel_vec;

`ifdef HAZARD_STATS_EN
   hazard_stats u_stats (
      .clk            (clk),
      .reset          (reset),
      .stall_i        (stall_pc),
      .flush_i        (flush_id_ex),
      .stat_stalls_o  (stat_stalls),
      .stat_flushes_o (stat_flushes)
   );
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: priority vector table plus interrupt,
// mem_busy, reset and statistics sequences.
module tb_hazard_ctrl;
   import hazard_pkg::*;

   logic clk = 1'b0;
   logic reset;
   logic [2:0] id_src1, id_src2, ex_wb_addr;
   logic id_use1, id_use2, ex_mr, ex_wb, ex_jmp_taken, mem_busy, int_req;
   logic stall_pc, stall_if_id, stall_id_ex, stall_ex_mem;
   logic flush_if_id, flush_id_ex, int_push_pc, int_push_flags, pc_sel_vec;
`ifdef HAZARD_STATS_EN
   logic [15:0] stat_stalls, stat_flushes;
`endif

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   hazard_ctrl #(.VEC_CYCLES(1)) dut (
      .clk            (clk),
      .reset          (reset),
      .id_src1        (id_src1),
      .id_src2        (id_src2),
      .id_use1        (id_use1),
      .id_use2        (id_use2),
      .ex_mr          (ex_mr),
      .ex_wb          (ex_wb),
      .ex_wb_addr     (ex_wb_addr),
      .ex_jmp_taken   (ex_jmp_taken),
      .mem_busy       (mem_busy),
      .int_req        (int_req),
      .stall_pc       (stall_pc),
      .stall_if_id    (stall_if_id),
      .stall_id_ex    (stall_id_ex),
      .stall_ex_mem   (stall_ex_mem),
      .flush_if_id    (flush_if_id),
      .flush_id_ex    (flush_id_ex),
      .int_push_pc    (int_push_pc),
      .int_push_flags (int_push_flags),
      .pc_sel_vec     (pc_sel_vec)
`ifdef HAZARD_STATS_EN
      ,
      .stat_stalls    (stat_stalls),
      .stat_flushes   (stat_flushes)
`endif
   );

   // Output order: stall_pc, stall_if_id, stall_id_ex, stall_ex_mem,
   //               flush_if_id, flush_id_ex, push_pc, push_flags, pc_sel_vec
   localparam logic [8:0] O_NONE   = 9'b000000000;
   localparam logic [8:0] O_BUBBLE = 9'b110001000;
   localparam logic [8:0] O_JUMP   = 9'b000011000;
   localparam logic [8:0] O_BUSY   = 9'b111100000;
   localparam logic [8:0] O_PUSHPC = 9'b100010100;
   localparam logic [8:0] O_PUSHFL = 9'b100010010;
   localparam logic [8:0] O_VECTOR = 9'b000010001;

   typedef struct {
      string      name;
      logic       busy, jmp, mr, wb, use1, use2;
      logic [2:0] addr, src1, src2;
      logic [8:0] exp;
   } vec_t;

   vec_t vecs[12];

   task automatic chk(input string nm, input logic [8:0] exp);
      logic [8:0] act;
      act = {stall_pc, stall_if_id, stall_id_ex, stall_ex_mem, flush_if_id,
             flush_id_ex, int_push_pc, int_push_flags, pc_sel_vec};
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s got=%b want=%b", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_in();
      id_src1 = 3'd0; id_src2 = 3'd0; ex_wb_addr = 3'd0;
      id_use1 = 1'b0; id_use2 = 1'b0; ex_mr = 1'b0; ex_wb = 1'b0;
      ex_jmp_taken = 1'b0; mem_busy = 1'b0;
   endtask

   task automatic set_lu();
      ex_mr = 1'b1; ex_wb = 1'b1; ex_wb_addr = 3'd3; id_src1 = 3'd3; id_use1 = 1'b1;
   endtask

   initial begin
      //          name            busy jmp mr wb u1 u2 addr src1 src2 exp
      vecs[0]  = '{"idle",        0, 0, 0, 0, 0, 0, 3'd0, 3'd0, 3'd0, O_NONE};
      vecs[1]  = '{"lu_src1",     0, 0, 1, 1, 1, 0, 3'd3, 3'd3, 3'd0, O_BUBBLE};
      vecs[2]  = '{"src1_unused", 0, 0, 1, 1, 0, 0, 3'd3, 3'd3, 3'd0, O_NONE};
      vecs[3]  = '{"lu_src2",     0, 0, 1, 1, 0, 1, 3'd5, 3'd1, 3'd5, O_BUBBLE};
      vecs[4]  = '{"no_mr",       0, 0, 0, 1, 1, 0, 3'd3, 3'd3, 3'd0, O_NONE};
      vecs[5]  = '{"no_wb",       0, 0, 1, 0, 1, 0, 3'd3, 3'd3, 3'd0, O_NONE};
      vecs[6]  = '{"addr_miss",   0, 0, 1, 1, 1, 1, 3'd3, 3'd2, 3'd4, O_NONE};
      vecs[7]  = '{"jmp_vs_lu",   0, 1, 1, 1, 1, 0, 3'd3, 3'd3, 3'd0, O_JUMP};
      vecs[8]  = '{"busy_all",    1, 1, 1, 1, 1, 0, 3'd3, 3'd3, 3'd0, O_BUSY};
      vecs[9]  = '{"busy_only",   1, 0, 0, 0, 0, 0, 3'd0, 3'd0, 3'd0, O_BUSY};
      vecs[10] = '{"lu_addr7",    0, 0, 1, 1, 1, 1, 3'd7, 3'd7, 3'd0, O_BUBBLE};
      vecs[11] = '{"lu_addr0",    0, 0, 1, 1, 0, 1, 3'd0, 3'd6, 3'd0, O_BUBBLE};

      clear_in();
      int_req = 1'b0;
      reset   = 1'b0;
      mem_busy = 1'b1;
      #2;
      chk("reset_forces_zero", O_NONE);
      mem_busy = 1'b0;
      tick();
      reset = 1'b1;
      @(negedge clk);
      chk("after_reset", O_NONE);

      for (int i = 0; i < 12; i++) begin
         tick();
         mem_busy = vecs[i].busy; ex_jmp_taken = vecs[i].jmp;
         ex_mr = vecs[i].mr; ex_wb = vecs[i].wb;
         id_use1 = vecs[i].use1; id_use2 = vecs[i].use2;
         ex_wb_addr = vecs[i].addr; id_src1 = vecs[i].src1; id_src2 = vecs[i].src2;
         @(negedge clk);
         chk(vecs[i].name, vecs[i].exp);
      end

      // Load-use: one bubble, then clean once the load has moved on.
      tick(); clear_in(); set_lu();
      @(negedge clk); chk("lu_bubble", O_BUBBLE);
      tick(); clear_in();
      @(negedge clk); chk("lu_clean", O_NONE);

      // Unobstructed interrupt with int_req held high afterwards.
      tick(); int_req = 1'b1;
      @(negedge clk); chk("int_edge_cycle", O_NONE);
      tick(); @(negedge clk); chk("int_push_pc", O_PUSHPC);
      tick(); @(negedge clk); chk("int_push_flags", O_PUSHFL);
      tick(); @(negedge clk); chk("int_vector", O_VECTOR);
      for (int i = 0; i < 3; i++) begin
         tick(); @(negedge clk); chk("int_held_quiet", O_NONE);
      end
      tick(); int_req = 1'b0;

      // Interrupt deferred by a taken jump on the edge cycle.
      tick(); int_req = 1'b1; ex_jmp_taken = 1'b1;
      @(negedge clk); chk("defer_jump", O_JUMP);
      tick(); ex_jmp_taken = 1'b0;
      @(negedge clk); chk("defer_retry", O_NONE);
      tick(); @(negedge clk); chk("defer_push_pc", O_PUSHPC);
      tick(); @(negedge clk); chk("defer_push_flags", O_PUSHFL);
      tick(); @(negedge clk); chk("defer_vector", O_VECTOR);
      tick(); int_req = 1'b0;
      @(negedge clk); chk("defer_done", O_NONE);

      // mem_busy for three cycles while in PUSH_FLAGS.
      tick(); int_req = 1'b1;
      tick(); @(negedge clk); chk("mb_push_pc", O_PUSHPC);
      tick(); mem_busy = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk); chk("mb_hold", O_BUSY);
         tick();
      end
      mem_busy = 1'b0;
      @(negedge clk); chk("mb_push_flags", O_PUSHFL);
      tick(); @(negedge clk); chk("mb_vector", O_VECTOR);
      tick(); @(negedge clk); chk("mb_done", O_NONE);
      tick(); int_req = 1'b0;

      // Asynchronous reset while in PUSH_PC.
      tick(); int_req = 1'b1;
      tick(); @(negedge clk); chk("rst_push_pc", O_PUSHPC);
      #1 reset = 1'b0;
      #1 chk("rst_async_drop", O_NONE);
      int_req = 1'b0;
      tick(); reset = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk); chk("rst_no_push", O_NONE);
         tick();
      end

`ifdef HAZARD_STATS_EN
      reset = 1'b0;
      #1 reset = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick(); clear_in(); set_lu();
         tick(); clear_in();
      end
      for (int i = 0; i < 2; i++) begin
         tick(); ex_jmp_taken = 1'b1;
         tick(); clear_in();
      end
      @(negedge clk);
      total++;
      if (stat_stalls !== 16'd5) begin
         bad++;
         $display("FAIL stat_stalls got=%0d want=5", stat_stalls);
      end
      total++;
      if (stat_flushes !== 16'd7) begin
         bad++;
         $display("FAIL stat_flushes got=%0d want=7", stat_flushes);
      end
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
